// File: rtl/wb_cfg_pkg.sv
// Shared bus widths, FSM state encodings and response constants for the
// Wishbone configuration master.
package wb_cfg_pkg;

  localparam int WB_ADR_W = 10;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [WB_DAT_W-1:0] RSP_DAT_NONE = '0;

endpackage

// File: rtl/wb_cfg_timer.sv
// Saturating bus-cycle timer; expired is high while the count sits at the
// last permitted cycle of a bus transfer.
module wb_cfg_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count_reg;

  assign expired = (count_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/wb_cfg_master.sv
// Wishbone classic single-transfer master: one command in, one bus cycle,
// one response out, with a forced termination if the slave never answers.
module wb_cfg_master
  import wb_cfg_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int TXN_CNT_W   = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [WB_ADR_W-1:0]  cmd_adr_i,
  input  logic [WB_SEL_W-1:0]  cmd_sel_i,
  input  logic [WB_DAT_W-1:0]  cmd_dat_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [WB_DAT_W-1:0]  rsp_dat_o,
  output logic                 rsp_err_o,
  output logic                 rsp_timeout_o,
  output logic [WB_ADR_W-1:0]  m_wb_adr_o,
  output logic [WB_SEL_W-1:0]  m_wb_sel_o,
  output logic                 m_wb_we_o,
  output logic [WB_DAT_W-1:0]  m_wb_dat_o,
  output logic                 m_wb_cyc_o,
  output logic                 m_wb_stb_o,
  input  logic [WB_DAT_W-1:0]  m_wb_dat_i,
  input  logic                 m_wb_ack_i,
  input  logic                 m_wb_err_i,
  output logic [TXN_CNT_W-1:0] txn_cnt_o
);

  logic [1:0]           state_reg;
  logic [WB_ADR_W-1:0]  adr_reg;
  logic [WB_SEL_W-1:0]  sel_reg;
  logic                 we_reg;
  logic [WB_DAT_W-1:0]  dat_reg;
  logic                 cyc_reg;
  logic                 rsp_valid_reg;
  logic [WB_DAT_W-1:0]  rsp_dat_reg;
  logic                 rsp_err_reg;
  logic                 rsp_timeout_reg;
  logic [TXN_CNT_W-1:0] txn_cnt_reg;

  logic in_bus;
  logic timer_expired;
  logic bus_done;

  assign in_bus   = (state_reg == ST_BUS);
  assign bus_done = in_bus && (m_wb_err_i || m_wb_ack_i || timer_expired);

  // Held at zero while idle so every transfer starts counting from cycle 0.
  wb_cfg_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (wb_clk_i),
    .srst   (wb_rst_i),
    .clear  (state_reg == ST_IDLE),
    .enable (in_bus && !m_wb_ack_i && !m_wb_err_i),
    .expired(timer_expired)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg       <= ST_IDLE;
      adr_reg         <= '0;
      sel_reg         <= '0;
      we_reg          <= 1'b0;
      dat_reg         <= '0;
      cyc_reg         <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_dat_reg     <= RSP_DAT_NONE;
      rsp_err_reg     <= 1'b0;
      rsp_timeout_reg <= 1'b0;
      txn_cnt_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            adr_reg   <= cmd_adr_i;
            sel_reg   <= cmd_sel_i;
            we_reg    <= cmd_we_i;
            dat_reg   <= cmd_dat_i;
            cyc_reg   <= 1'b1;
            state_reg <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (bus_done) begin
            cyc_reg         <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            rsp_err_reg     <= m_wb_err_i;
            // A late ack on the expiry cycle still wins over the timeout.
            rsp_timeout_reg <= !m_wb_err_i && !m_wb_ack_i;
            rsp_dat_reg     <= (!m_wb_err_i && m_wb_ack_i && !we_reg) ? m_wb_dat_i
                                                                      : RSP_DAT_NONE;
            txn_cnt_reg     <= txn_cnt_reg + 1'b1;
            state_reg       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_reg   <= 1'b0;
            rsp_dat_reg     <= RSP_DAT_NONE;
            rsp_err_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
            state_reg       <= ST_IDLE;
          end
        end
        default: begin
          cyc_reg   <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o   = (state_reg == ST_IDLE);
  assign rsp_valid_o   = rsp_valid_reg;
  assign rsp_dat_o     = rsp_dat_reg;
  assign rsp_err_o     = rsp_err_reg;
  assign rsp_timeout_o = rsp_timeout_reg;
  assign m_wb_adr_o    = adr_reg;
  assign m_wb_sel_o    = sel_reg;
  assign m_wb_we_o     = we_reg;
  assign m_wb_dat_o    = dat_reg;
  assign m_wb_cyc_o    = cyc_reg;
  assign m_wb_stb_o    = cyc_reg;
  assign txn_cnt_o     = txn_cnt_reg;

endmodule

// File: tb/tb_wb_cfg_master.sv
// Directed bench for wb_cfg_master with an 8-cycle timeout; the bus slave is
// driven by hand from the stimulus sequence.
module tb_wb_cfg_master;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [9:0]  cmd_adr;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_dat;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [9:0]  wb_adr;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic [31:0] wb_dat_o;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_dat_i;
  logic        wb_ack;
  logic        wb_err;
  logic [15:0] txn_cnt;

  int checks;
  int errors;
  int ncyc;

  wb_cfg_master #(
    .TIMEOUT_CYC(8),
    .TXN_CNT_W  (16)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_we_i     (cmd_we),
    .cmd_adr_i    (cmd_adr),
    .cmd_sel_i    (cmd_sel),
    .cmd_dat_i    (cmd_dat),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_dat_o    (rsp_dat),
    .rsp_err_o    (rsp_err),
    .rsp_timeout_o(rsp_timeout),
    .m_wb_adr_o   (wb_adr),
    .m_wb_sel_o   (wb_sel),
    .m_wb_we_o    (wb_we),
    .m_wb_dat_o   (wb_dat_o),
    .m_wb_cyc_o   (wb_cyc),
    .m_wb_stb_o   (wb_stb),
    .m_wb_dat_i   (wb_dat_i),
    .m_wb_ack_i   (wb_ack),
    .m_wb_err_i   (wb_err),
    .txn_cnt_o    (txn_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while idle; returns at the negedge after acceptance.
  task automatic send_cmd(input logic we, input logic [9:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_sel   = sel;
    cmd_dat   = dat;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_dat   = 32'h0;
  endtask

  // Plays the slave: counts cyc-high cycles, raising ack/err on the chosen one.
  task automatic bus_phase(input int ack_on, input int err_on, input logic [31:0] rdata,
                           output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!wb_cyc) break;
      n++;
      wb_ack   = (n == ack_on);
      wb_err   = (n == err_on);
      wb_dat_i = (n == ack_on) ? rdata : 32'hDEAD_BEEF;
      @(negedge clk);
    end
    wb_ack   = 1'b0;
    wb_err   = 1'b0;
    wb_dat_i = 32'h0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_sel   = '0;
    cmd_dat   = '0;
    rsp_ready = 1'b0;
    wb_dat_i  = '0;
    wb_ack    = 1'b0;
    wb_err    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_txn", txn_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    // Write, acked in the first stb cycle.
    send_cmd(1'b1, 10'h000, 4'hF, 32'h0000_A423);
    chk("wr_cyc", wb_cyc, 1);
    chk("wr_stb", wb_stb, 1);
    chk("wr_adr", wb_adr, 10'h000);
    chk("wr_dat", wb_dat_o, 32'h0000_A423);
    chk("wr_we", wb_we, 1);
    chk("wr_sel", wb_sel, 4'hF);
    chk("wr_busy", cmd_ready, 0);
    bus_phase(1, 0, 32'hFFFF_FFFF, ncyc);
    chk("wr_ncyc", ncyc, 1);
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_dat", rsp_dat, 0);
    chk("wr_rsp_err", rsp_err, 0);
    chk("wr_rsp_to", rsp_timeout, 0);
    chk("wr_txn", txn_cnt, 1);
    consume();
    chk("wr_consumed", rsp_valid, 0);
    chk("wr_idle", cmd_ready, 1);

    // Read with three wait states.
    send_cmd(1'b0, 10'h010, 4'hF, 32'h0);
    chk("rd_we", wb_we, 0);
    chk("rd_adr", wb_adr, 10'h010);
    bus_phase(4, 0, 32'h1234_5678, ncyc);
    chk("rd_ncyc", ncyc, 4);
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_dat", rsp_dat, 32'h1234_5678);
    chk("rd_rsp_err", rsp_err, 0);
    chk("rd_rsp_to", rsp_timeout, 0);
    chk("rd_txn", txn_cnt, 2);
    consume();

    // Ack and err together: err takes priority.
    send_cmd(1'b0, 10'h005, 4'h3, 32'h0);
    bus_phase(2, 2, 32'hCAFE_F00D, ncyc);
    chk("err_ncyc", ncyc, 2);
    chk("err_rsp_err", rsp_err, 1);
    chk("err_rsp_dat", rsp_dat, 0);
    chk("err_rsp_to", rsp_timeout, 0);
    chk("err_txn", txn_cnt, 3);
    consume();

    // Silent slave: forced termination after 8 cycles.
    send_cmd(1'b0, 10'h020, 4'hF, 32'h0);
    bus_phase(0, 0, 32'h0, ncyc);
    chk("to_ncyc", ncyc, 8);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_to", rsp_timeout, 1);
    chk("to_rsp_dat", rsp_dat, 0);
    chk("to_rsp_err", rsp_err, 0);
    chk("to_txn", txn_cnt, 4);
    consume();

    // Ack on the expiry cycle is a normal completion.
    send_cmd(1'b0, 10'h021, 4'hF, 32'h0);
    bus_phase(8, 0, 32'hA5A5_0008, ncyc);
    chk("late_ncyc", ncyc, 8);
    chk("late_rsp_to", rsp_timeout, 0);
    chk("late_rsp_dat", rsp_dat, 32'hA5A5_0008);
    chk("late_txn", txn_cnt, 5);
    consume();

    // Backpressure with a second command waiting.
    send_cmd(1'b0, 10'h030, 4'hF, 32'h0);
    bus_phase(1, 0, 32'h0BAD_CAFE, ncyc);
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_adr   = 10'h155;
    cmd_sel   = 4'h5;
    cmd_dat   = 32'h5555_AAAA;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_dat", rsp_dat, 32'h0BAD_CAFE);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_cyc", wb_cyc, 0);
      @(negedge clk);
    end
    consume();
    chk("bp_released", rsp_valid, 0);
    chk("bp_ready", cmd_ready, 1);
    chk("bp_no_cyc", wb_cyc, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp2_cyc", wb_cyc, 1);
    chk("bp2_adr", wb_adr, 10'h155);
    chk("bp2_dat", wb_dat_o, 32'h5555_AAAA);
    bus_phase(1, 0, 32'h0, ncyc);
    chk("bp2_rsp_valid", rsp_valid, 1);
    chk("bp2_txn", txn_cnt, 7);
    consume();

    // Reset in the middle of a bus cycle.
    send_cmd(1'b1, 10'h3FF, 4'hF, 32'h1111_2222);
    @(negedge clk);
    chk("mr_cyc_before", wb_cyc, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_cyc", wb_cyc, 0);
    chk("mr_stb", wb_stb, 0);
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_cmd_ready", cmd_ready, 1);
    chk("mr_txn", txn_cnt, 0);
    chk("mr_adr", wb_adr, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mr_no_rsp", rsp_valid, 0);
    end
    send_cmd(1'b0, 10'h002, 4'hF, 32'h0);
    bus_phase(2, 0, 32'h0000_0001, ncyc);
    chk("mr2_rsp_valid", rsp_valid, 1);
    chk("mr2_rsp_dat", rsp_dat, 32'h0000_0001);
    chk("mr2_txn", txn_cnt, 1);
    consume();
    chk("mr2_done", rsp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_cfg_master.md
# wb_cfg_master

Wishbone classic single-cycle master that converts register read/write commands from the testbench/config sequencer into bus cycles on the Ethernet MAC host register port. It sits directly upstream of the MAC's WISHBONE slave interface (10-bit word address, 32-bit data, byte selects, ack/err termination) and returns one response per command. It adds a cycle timeout and a transaction counter so that a hung slave cannot stall configuration.

## Interface
- TIMEOUT_CYC, 255: maximum cycles cyc/stb stay asserted without ack/err before forced termination (legal range 2..65535).
- TXN_CNT_W, 16: width of the completed-transaction counter.
- wb_clk_i  in  1  single clock; all logic on rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  block accepts command this cycle.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  10  word address [11:2].
- cmd_sel_i  in  4  byte selects.
- cmd_dat_i  in  32  write data.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed.
- rsp_dat_o  out  32  read data (0 for writes, errors and timeouts).
- rsp_err_o  out  1  slave signalled err.
- rsp_timeout_o  out  1  cycle was force-terminated.
- m_wb_adr_o  out  10  to MAC wb_adr_i.
- m_wb_sel_o  out  4  to MAC wb_sel_i.
- m_wb_we_o  out  1  to MAC wb_we_i.
- m_wb_dat_o  out  32  to MAC wb_dat_i.
- m_wb_cyc_o  out  1  to MAC wb_cyc_i.
- m_wb_stb_o  out  1  to MAC wb_stb_i.
- m_wb_dat_i  in  32  from MAC wb_dat_o.
- m_wb_ack_i  in  1  from MAC wb_ack_o.
- m_wb_err_i  in  1  from MAC wb_err_o.
- txn_cnt_o  out  TXN_CNT_W  count of completed responses (ack, err or timeout).

## Operation
- States: IDLE, BUS, RESP.
- IDLE: cmd_ready_o = 1. On cmd_valid_i, latch we/adr/sel/dat into m_wb_* registers, set cyc/stb, clear timer, go to BUS.
- BUS: cyc = stb = 1, address/data/we/sel held stable. Timer increments each cycle with no ack/err. Termination is evaluated in this priority:
  - err: rsp_err = 1, rsp_dat = 0.
  - ack: rsp_dat = m_wb_dat_i for reads, 0 for writes.
  - timer == TIMEOUT_CYC-1: rsp_timeout = 1, rsp_dat = 0.
- On termination: drop cyc/stb, set rsp_valid, increment txn_cnt_o (wraps modulo 2^TXN_CNT_W), go to RESP.
- RESP: hold all rsp_* stable until rsp_ready_i. Then clear rsp_valid and go to IDLE.
- ack/err while in IDLE or RESP: ignored.
- Reset (any state): on the next edge, every output is 0 except cmd_ready_o = 1. State returns to IDLE, timer and txn_cnt clear. An in-flight bus cycle is abandoned with no response.

## Timing
- Command accepted at edge N: cyc/stb are high from cycle N+1.
- Ack sampled high at edge M: cyc/stb are low and rsp_valid is high from M+1. The minimum command-to-response latency is therefore 2 cycles.
- Timeout: cyc/stb are high for exactly TIMEOUT_CYC cycles, then drop together with rsp_valid rising.
- Ack arriving in the same cycle the timer expires counts as a normal ack (no timeout flag).
- Back-to-back throughput: one command per 3 cycles minimum, with rsp_ready_i tied high.
- No combinational path from any input to any output. cmd_ready_o is decoded from registered state only.

## Structure
- Package wb_cfg_pkg holds:
  - State enum (IDLE, BUS, RESP).
  - WB_ADR_W = 10 and WB_DAT_W = 32.
  - Response-data constant for error/timeout (32'h0).
- Sub-module wb_cfg_timer holds the saturating cycle counter and expiry compare.
  - Counter width is $clog2(TIMEOUT_CYC).
  - Inputs: clear, enable. Output: expired.

## Test plan
- Write: cmd we=1 adr=10'h000 sel=4'hF dat=32'h0000_A423; slave acks 1 cycle after stb. Expected: bus carries adr/dat/we/sel unchanged; rsp_valid 2 cycles after acceptance with rsp_dat=0, err=0, timeout=0; txn_cnt=1.
- Read: read adr=10'h010; slave returns 32'h1234_5678 with ack after 3 wait cycles. Expected: rsp_dat=32'h1234_5678; cyc high for exactly 4 cycles.
- Err: slave asserts ack and err in the same cycle. Expected: rsp_err=1, rsp_dat=0.
- Timeout: TIMEOUT_CYC=8 with a slave that never responds. Expected: cyc high exactly 8 cycles, then rsp_timeout=1. Repeat with ack on the 8th cycle: expected timeout=0.
- Backpressure: hold rsp_ready_i low 5 cycles, with a second command pending. Expected: rsp fields stable, cmd_ready_o=0, no new cyc until the response is consumed.
- Reset: assert wb_rst_i mid-BUS. Expected: next edge cyc/stb=0, rsp_valid=0, cmd_ready=1, txn_cnt=0, no response emitted. A new command then completes normally.
